// File: rtl/cpu_hatch_loader.sv
// cpu_hatch_loader
//   Boot-time program loader for a small CPU. A byte stream fills a
//   2048 x 48-bit instruction memory while the CPU is held in reset. The CPU
//   fetch stage reads the same memory through a registered read port.
//
//   Load stream: count_hi (bits [2:0] used), count_lo, then count words of
//   six bytes each, MSB first. With HATCH_LOADER_CHECKSUM_EN defined, one
//   more byte follows: the XOR of the count bytes and all data bytes.
//
// Ports
//   clk                system clock
//   rst                synchronous active-high reset
//   hatch_address      CPU fetch address, bits [10:0] used (wraps)
//   hatch_instruction  registered read data, 1-cycle latency
//   ld_start           pulse that starts a load (from IDLE or ERROR)
//   ld_data/ld_valid   load byte stream
//   ld_ready           a byte is accepted this cycle when ld_valid is high
//   cpu_rst_b          active-low CPU reset, released only in IDLE
//   ld_busy            load or release countdown in progress
//   ld_error           sticky checksum failure
//
// Build option
//   HATCH_LOADER_CHECKSUM_EN  adds the checksum byte and the ERROR state;
//                             when undefined, ld_error is tied low.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | CPU running, waiting for ld_start
// CNT_HI | waiting for the upper count byte
// CNT_LO | waiting for the lower count byte
// DATA   | collecting six-byte words and writing them to memory
// CSUM   | waiting for the checksum byte (checksum build only)
// HOLD   | CPU held in reset for four cycles before release
// ERROR  | checksum mismatch, CPU held until the next ld_start

module cpu_hatch_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hatch_address,
  output logic [47:0] hatch_instruction,
  input  logic        ld_start,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        cpu_rst_b,
  output logic        ld_busy,
  output logic        ld_error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
`ifdef HATCH_LOADER_CHECKSUM_EN
    CSUM   = 3'd4,
    ERROR  = 3'd6,
`endif
    HOLD   = 3'd5
  } state_t;

`ifdef HATCH_LOADER_CHECKSUM_EN
  localparam state_t DONE_STATE = CSUM;
`else
  localparam state_t DONE_STATE = HOLD;
`endif

  logic [47:0] mem [0:2047];

  state_t      state;
  logic [1:0]  rel_cnt;
  logic [10:0] waddr;
  logic [10:0] count;
  logic [2:0]  byte_idx;
  logic [39:0] word_sr;
  logic        xfer;
  logic        mem_we;
  logic        last_word;
  logic        unused_addr_hi;
`ifdef HATCH_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign unused_addr_hi = ^hatch_address[31:11];

  assign xfer      = ld_valid && ld_ready;
  assign mem_we    = (state == DATA) && xfer && (byte_idx == 3'd5);
  assign last_word = (waddr == count - 11'd1);

  always_comb begin
    ld_ready = 1'b0;
    case (state)
      CNT_HI, CNT_LO, DATA: ld_ready = 1'b1;
`ifdef HATCH_LOADER_CHECKSUM_EN
      CSUM:                 ld_ready = 1'b1;
`endif
      default:              ld_ready = 1'b0;
    endcase
  end

  assign cpu_rst_b = (state == IDLE);
`ifdef HATCH_LOADER_CHECKSUM_EN
  assign ld_busy   = (state != IDLE) && (state != ERROR);
`else
  assign ld_busy   = (state != IDLE);
  assign ld_error  = 1'b0;
`endif

  // Write port: no reset, so an abandoned load keeps the words it wrote.
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= {word_sr, ld_data};
  end

  // Read port: nonblocking read sees pre-write contents on an address clash.
  always_ff @(posedge clk) begin
    if (rst) hatch_instruction <= 48'd0;
    else     hatch_instruction <= mem[hatch_address[10:0]];
  end

  // Release down-counter: preloaded outside HOLD, so it holds 3 on entry.
  always_ff @(posedge clk) begin
    if (rst || state != HOLD) rel_cnt <= 2'd3;
    else if (rel_cnt != 2'd0) rel_cnt <= rel_cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      waddr    <= 11'd0;
      byte_idx <= 3'd0;
      count    <= 11'd0;
      word_sr  <= 40'd0;
`ifdef HATCH_LOADER_CHECKSUM_EN
      csum     <= 8'd0;
      ld_error <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= CNT_HI;
            waddr    <= 11'd0;
            byte_idx <= 3'd0;
`ifdef HATCH_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        CNT_HI: begin
          if (xfer) begin
            count[10:8] <= ld_data[2:0];
            state       <= CNT_LO;
`ifdef HATCH_LOADER_CHECKSUM_EN
            csum        <= csum ^ ld_data;
`endif
          end
        end
        CNT_LO: begin
          if (xfer) begin
            count[7:0] <= ld_data;
`ifdef HATCH_LOADER_CHECKSUM_EN
            csum       <= csum ^ ld_data;
`endif
            if ({count[10:8], ld_data} == 11'd0) state <= DONE_STATE;
            else                                 state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef HATCH_LOADER_CHECKSUM_EN
            csum <= csum ^ ld_data;
`endif
            if (byte_idx == 3'd5) begin
              byte_idx <= 3'd0;
              waddr    <= waddr + 11'd1;
              if (last_word) state <= DONE_STATE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              word_sr  <= {word_sr[31:0], ld_data};
            end
          end
        end
`ifdef HATCH_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            if (ld_data == csum) begin
              state <= HOLD;
            end else begin
              state    <= ERROR;
              ld_error <= 1'b1;
            end
          end
        end
        ERROR: begin
          if (ld_start) begin
            state    <= CNT_HI;
            ld_error <= 1'b0;
            waddr    <= 11'd0;
            byte_idx <= 3'd0;
            csum     <= 8'd0;
          end
        end
`endif
        HOLD: begin
          if (rel_cnt == 2'd0) state <= IDLE;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_hatch_loader.sv
// Testbench for cpu_hatch_loader: random and directed loads checked against a
// word-level model of the instruction memory built from the load byte stream.
module tb_cpu_hatch_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hatch_address;
  logic [47:0] hatch_instruction;
  logic        ld_start;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        cpu_rst_b;
  logic        ld_busy;
  logic        ld_error;

  int checks   = 0;
  int failures = 0;

  logic [47:0] model_mem [2048];
  bit          written   [2048];
  logic [7:0]  data_q    [$];

  always #5 clk = ~clk;

  cpu_hatch_loader dut (
    .clk               (clk),
    .rst               (rst),
    .hatch_address     (hatch_address),
    .hatch_instruction (hatch_instruction),
    .ld_start          (ld_start),
    .ld_data           (ld_data),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .cpu_rst_b         (cpu_rst_b),
    .ld_busy           (ld_busy),
    .ld_error          (ld_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte; with stall set, ld_valid is random and ld_start is pulsed randomly.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      ld_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = ld_valid ? b : 8'($urandom);
      ld_start = stall && ($urandom_range(0, 7) == 0);
      done     = ld_valid && ld_ready;
      tick();
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    chk("byte_accepted", {63'd0, done}, 64'd1);
  endtask

  task automatic check_release(input string tag);
    int low = 0;
    while (!cpu_rst_b && low < 50) begin
      chk({tag, "_busy_hold"}, {63'd0, ld_busy}, 64'd1);
      low++;
      tick();
    end
    chk({tag, "_hold_cycles"}, 64'(low), 64'd4);
    chk({tag, "_busy_idle"}, {63'd0, ld_busy}, 64'd0);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (ld_busy && n < 100) begin
      n++;
      tick();
    end
    chk("wait_not_busy", {63'd0, ld_busy}, 64'd0);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("start_ld_error", {63'd0, ld_error}, 64'd0);
    chk("start_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("start_cpu_rst_b", {63'd0, cpu_rst_b}, 64'd0);
  endtask

  // Expected memory after count words from data_q land at addresses 0..count-1.
  task automatic model_apply(input int cnt);
    logic [47:0] w;
    for (int i = 0; i < cnt; i++) begin
      w = 48'd0;
      for (int k = 0; k < 6; k++) w = (w << 8) | 48'(data_q[6*i+k]);
      model_mem[i] = w;
      written[i]   = 1'b1;
    end
  endtask

  task automatic load_prog(input logic [7:0] hi, input logic [7:0] lo, input bit stall,
                           input bit bad_csum, input string tag);
    logic [7:0] x;
    int cnt;
    wait_not_busy();
    pulse_start();
    cnt = int'({hi[2:0], lo});
    x = hi ^ lo;
    send_byte(hi, stall);
    send_byte(lo, stall);
    for (int i = 0; i < cnt * 6; i++) begin
      send_byte(data_q[i], stall);
      x ^= data_q[i];
    end
    model_apply(cnt);
`ifdef HATCH_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, stall);
    if (bad_csum) begin
      chk({tag, "_ld_error"}, {63'd0, ld_error}, 64'd1);
      for (int i = 0; i < 8; i++) begin
        chk({tag, "_err_cpu_rst_b"}, {63'd0, cpu_rst_b}, 64'd0);
        tick();
      end
      chk({tag, "_err_busy"}, {63'd0, ld_busy}, 64'd0);
      chk({tag, "_err_sticky"}, {63'd0, ld_error}, 64'd1);
      return;
    end
`else
    if (bad_csum) x = 8'd0;
`endif
    check_release(tag);
    chk({tag, "_ld_error"}, {63'd0, ld_error}, 64'd0);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr);
    hatch_address = addr;
    tick();
    if (written[addr[10:0]])
      chk(tag, {16'd0, hatch_instruction}, {16'd0, model_mem[addr[10:0]]});
  endtask

  task automatic fill_random(input int nbytes);
    data_q.delete();
    for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom));
  endtask

  initial begin
    logic [47:0] old_w;
    rst           = 1'b1;
    hatch_address = 32'd0;
    ld_start      = 1'b0;
    ld_data       = 8'd0;
    ld_valid      = 1'b0;

    // Reset state and release countdown.
    tick();
    chk("rst_instr", {16'd0, hatch_instruction}, 64'd0);
    chk("rst_cpu_rst_b", {63'd0, cpu_rst_b}, 64'd0);
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
    chk("rst_ld_busy", {63'd0, ld_busy}, 64'd1);
    chk("rst_ld_error", {63'd0, ld_error}, 64'd0);
    rst = 1'b0;
    check_release("por");

    // ld_valid with ld_ready low does nothing.
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'($urandom);
      tick();
      chk("idle_valid_busy", {63'd0, ld_busy}, 64'd0);
      chk("idle_valid_ready", {63'd0, ld_ready}, 64'd0);
    end
    ld_valid = 1'b0;

    // Two-word directed load.
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    load_prog(8'h00, 8'h02, 1'b0, 1'b0, "two");
    hatch_address = 32'd0;
    tick();
    chk("two_w0", {16'd0, hatch_instruction}, 64'h112233445566);
    hatch_address = 32'd1;
    tick();
    chk("two_w1", {16'd0, hatch_instruction}, 64'h0000AABBCCDDEEFF);
    hatch_address = 32'h0000_0801;
    tick();
    chk("wrap_801", {16'd0, hatch_instruction}, 64'h0000AABBCCDDEEFF);
    read_chk("wrap_rand", {21'($urandom), 11'd0});

    // Random five-word load under backpressure, then the directed load again.
    fill_random(30);
    load_prog(8'h00, 8'h05, 1'b1, 1'b0, "rand5");
    for (int a = 0; a < 5; a++) read_chk("rand5_rd", 32'(a));
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    load_prog(8'h00, 8'h02, 1'b1, 1'b0, "two_bp");
    hatch_address = 32'd0;
    tick();
    chk("two_bp_w0", {16'd0, hatch_instruction}, 64'h112233445566);
    hatch_address = 32'd1;
    tick();
    chk("two_bp_w1", {16'd0, hatch_instruction}, 64'h0000AABBCCDDEEFF);
    for (int a = 2; a < 5; a++) read_chk("two_bp_keep", 32'(a));

    // Count bytes F8 00 mean zero words: straight to release, memory untouched.
    data_q.delete();
    load_prog(8'hF8, 8'h00, 1'b0, 1'b0, "zero");
    for (int a = 0; a < 5; a++) read_chk("zero_keep", 32'(a));

    // Same-address read during the write returns the old word, then the new one.
    old_w = model_mem[0];
    fill_random(6);
    hatch_address = 32'd0;
    wait_not_busy();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(data_q[i], 1'b0);
    chk("rw_same_old", {16'd0, hatch_instruction}, {16'd0, old_w});
    model_apply(1);
    tick();
    chk("rw_same_new", {16'd0, hatch_instruction}, {16'd0, model_mem[0]});
`ifdef HATCH_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h01;
      for (int i = 0; i < 6; i++) x ^= data_q[i];
      send_byte(x, 1'b0);
    end
    check_release("rw_same");
`else
    wait_not_busy();
`endif

    // Reset mid-load: first word kept, partial second word discarded.
    fill_random(18);
    wait_not_busy();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(data_q[i], 1'b0);
    model_apply(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_instr", {16'd0, hatch_instruction}, 64'd0);
    chk("midrst_ready", {63'd0, ld_ready}, 64'd0);
    check_release("midrst");
    for (int a = 0; a < 5; a++) read_chk("midrst_rd", 32'(a));

    // Count bytes 07 FF: 2047 words.
    fill_random(2047 * 6);
    load_prog(8'h07, 8'hFF, 1'b0, 1'b0, "full");
    read_chk("full_first", 32'd0);
    read_chk("full_last", 32'd2046);
    for (int i = 0; i < 10; i++)
      read_chk("full_rand", {21'($urandom), 11'($urandom_range(0, 2046))});

`ifdef HATCH_LOADER_CHECKSUM_EN
    // Bad checksum holds the CPU; a correct load clears the error.
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    load_prog(8'h00, 8'h02, 1'b0, 1'b1, "bad_csum");
    fill_random(12);
    load_prog(8'h00, 8'h02, 1'b1, 1'b0, "after_err");
    read_chk("after_err_w0", 32'd0);
    read_chk("after_err_w1", 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
